sd_spi: RTL
===========

# sd_spi

SPI master for the SD card slot, directly downstream of the memory/port controller. It consumes the SD-CMD / SD-DAT port latches (`sd_cmd`, `sd_out`, `sd_signal`) and returns `sd_din`, `sd_busy` and `sd_timeout` to the same controller for reading by the AVR. It performs four operations: card init clocking, full-duplex byte exchange, chip-select assert and chip-select release. Each command is started by the CPU toggling bit 7 of SD-CMD.

## Interface
Parameters:
- `SLOW_DIV`, 64: SCLK half-period in `clock` cycles during INIT (≤400 kHz).
- `FAST_DIV`, 2: SCLK half-period in `clock` cycles during XFER; ≥1.
- `TIMEOUT`, 1048576: idle cycles with CS asserted before `sd_timeout` sets.

Ports:
- `clock`, in, 1: system clock. One clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `sd_signal`, in, 1: command strobe latch; a level change starts a command.
- `sd_cmd`, in, 2: 0=INIT, 1=XFER, 2=CE0 (CS low), 3=CE1 (CS high).
- `sd_out`, in, 8: byte to transmit on XFER.
- `sd_din`, out, 8: last byte received.
- `sd_busy`, out, 1: command in progress.
- `sd_timeout`, out, 1: idle watchdog expired.
- `spi_cs`, out, 1: card chip select, active low.
- `spi_sclk`, out, 1: SPI clock, idle low (mode 0).
- `spi_mosi`, out, 1: data to card.
- `spi_miso`, in, 1: data from card.

## Operation
- Reset values: `spi_cs`=1, `spi_sclk`=0, `spi_mosi`=1, `sd_busy`=0, `sd_timeout`=0, `sd_din`=8'hFF, state IDLE. Internal `sig_ack` loads the current `sd_signal`, so reset never triggers a command.
- Start: in IDLE, `sd_signal != sig_ack` accepts a command on that edge.
  - On acceptance: `sig_ack <= sd_signal`, `sd_cmd` and `sd_out` are captured, the timeout counter and `sd_timeout` clear, and `sd_busy <= 1`.
  - A toggle while busy is not lost. It stays pending and is accepted on the first IDLE cycle.
  - Port values are sampled only at acceptance.
- States:
  - IDLE → INIT / XFER / CS (chosen by the captured command).
  - INIT: CS forced high, MOSI=1. Runs 80 SCLK periods at `SLOW_DIV`, then → IDLE. `spi_cs` afterwards keeps its pre-INIT value.
  - XFER: shift register loads `sd_out`; `spi_mosi`=bit 7 on entry. Each bit is:
    - `FAST_DIV` cycles, then SCLK rises and MISO is sampled into bit 0;
    - `FAST_DIV` cycles, then SCLK falls and the register shifts left, driving the next MOSI.
    - After the 8th falling edge: `sd_din <=` received byte, `spi_mosi`=1, → IDLE.
    - MSB first.
  - CS: `spi_cs <= (cmd==CE1)`, → IDLE.
- Watchdog:
  - In IDLE with `spi_cs`=0, a counter increments every cycle.
  - When it reaches `TIMEOUT-1`, `sd_timeout` sets and stays set; the counter saturates.
  - The counter holds at 0 while `spi_cs`=1 or while busy.
  - Only an accepted command clears `sd_timeout`. Software uses this to bound response polling loops.
- Reset during any state aborts immediately on that edge. All outputs take their reset values and no partial byte is written to `sd_din`.

## Timing
- Acceptance edge E: `sd_busy` is 1 after E.
- Busy duration, counted from E until `sd_busy` returns to 0:
  - CS: exactly 1 cycle.
  - XFER: exactly 16·`FAST_DIV` cycles.
  - INIT: exactly 160·`SLOW_DIV` cycles.
- `sd_din` updates on the same edge on which `sd_busy` falls.
- The earliest next acceptance is the cycle after `sd_busy` falls; no bubble beyond that.
- MISO is sampled on the same `clock` edge that drives SCLK high; the card has one half-period of setup.
- All outputs are registered; no combinational path exists from inputs to outputs.

## Structure
- Package `sd_spi_pkg` holds:
  - command encodings `CMD_INIT`, `CMD_XFER`, `CMD_CE0`, `CMD_CE1`;
  - the state enum `IDLE`, `INIT`, `XFER`, `CS`;
  - the INIT edge count constant (160).
- Sub-module `sd_spi_tick`: half-period counter.
  - Takes a divider select (slow/fast) and an enable.
  - Emits a one-cycle `tick` every N cycles and restarts on enable rise.
  - The FSM toggles SCLK on each tick.
- Counter widths use `$clog2` of the largest parameter.

## Test plan
All scenarios use `FAST_DIV`=2, `SLOW_DIV`=4, `TIMEOUT`=100.
- Reset with `sd_signal`=1 held → no command starts. `spi_cs`=1, `spi_sclk`=0, `sd_din`=FF, `sd_busy`=0.
- CE0 toggle → `spi_cs`=0 after 1 busy cycle. Then CE1 → `spi_cs`=1 after 1 busy cycle.
- CE0, then XFER `sd_out`=8'hA5 with the card model returning 8'h3C:
  - MOSI shows 1,0,1,0,0,1,0,1;
  - 8 SCLK pulses;
  - `sd_busy` high exactly 32 cycles;
  - `sd_din`=3C.
- INIT → 80 SCLK rising edges, `spi_cs`=1 and MOSI=1 throughout, busy exactly 640 cycles.
- CE0 then idle 100 cycles → `sd_timeout`=1 from cycle 100 and stays set. A following XFER clears it on acceptance.
- Toggle `sd_signal` mid-XFER → second XFER accepted the cycle after busy falls. Separately, assert `reset` mid-XFER → immediate reset values, `sd_din` unchanged from FF.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared encodings for the SD-card SPI master: command codes, FSM states
// and SCLK edge counts per operation.
package sd_spi_pkg;

    localparam logic [1:0] CMD_INIT = 2'd0;
    localparam logic [1:0] CMD_XFER = 2'd1;
    localparam logic [1:0] CMD_CE0  = 2'd2;
    localparam logic [1:0] CMD_CE1  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        XFER = 2'd2,
        CS   = 2'd3
    } state_t;

    // SCLK edges (rising + falling) per operation: 80 init clocks, 8 data bits.
    localparam int INIT_EDGES = 160;
    localparam int XFER_EDGES = 16;

endpackage

// File: rtl/sd_spi_tick.sv
// SCLK half-period timer: pulses o_tick once every SLOW_DIV or FAST_DIV
// cycles while enabled, and restarts from zero whenever enable drops.
module sd_spi_tick #(
    parameter int SLOW_DIV = 64,
    parameter int FAST_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_en,
    input  logic i_slow,
    output logic o_tick
);
    localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int CNT_W   = $clog2(MAX_DIV + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_limit;

    assign w_limit = i_slow ? CNT_W'(SLOW_DIV - 1) : CNT_W'(FAST_DIV - 1);
    assign o_tick  = i_en && (r_cnt == w_limit);

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock) begin
        if (reset || !i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sd_spi.sv
// SPI master (mode 0) for the SD slot: init clocking, byte exchange and
// chip-select control, started by a level change on sd_signal.
module sd_spi
    import sd_spi_pkg::*;
#(
    parameter int SLOW_DIV = 64,
    parameter int FAST_DIV = 2,
    parameter int TIMEOUT  = 1048576
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sd_signal,
    input  logic [1:0] sd_cmd,
    input  logic [7:0] sd_out,
    output logic [7:0] sd_din,
    output logic       sd_busy,
    output logic       sd_timeout,
    output logic       spi_cs,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);
    localparam int              WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [7:0]      INIT_LAST = 8'(INIT_EDGES - 1);
    localparam logic [7:0]      XFER_LAST = 8'(XFER_EDGES - 1);

    state_t          r_state, w_next;
    logic            r_sig_ack;
    logic [1:0]      r_cmd;
    logic [7:0]      r_shift;
    logic [7:0]      r_edge_cnt;
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_cs_hold;
    logic            r_spi_cs, r_sclk, r_mosi, r_busy, r_timeout;
    logic [7:0]      r_din;

    logic w_tick, w_tick_en, w_tick_slow;
    logic w_accept, w_done, w_rise, w_fall;

    assign w_tick_en   = (r_state == INIT) || (r_state == XFER);
    assign w_tick_slow = (r_state == INIT);

    sd_spi_tick #(
        .SLOW_DIV(SLOW_DIV),
        .FAST_DIV(FAST_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .i_en  (w_tick_en),
        .i_slow(w_tick_slow),
        .o_tick(w_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) begin
                case (sd_cmd)
                    CMD_INIT: w_next = INIT;
                    CMD_XFER: w_next = XFER;
                    default:  w_next = CS;
                endcase
            end
            INIT, XFER: if (w_done) w_next = IDLE;
            CS:         w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        w_accept = (r_state == IDLE) && (sd_signal != r_sig_ack);
        w_done   = w_tick && (r_edge_cnt == ((r_state == INIT) ? INIT_LAST : XFER_LAST));
        w_rise   = w_tick && !r_sclk;
        w_fall   = w_tick && r_sclk;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // Loading the live strobe level means reset never looks like a toggle.
            r_sig_ack  <= sd_signal;
            r_cmd      <= CMD_CE1;
            r_shift    <= 8'hFF;
            r_edge_cnt <= '0;
            r_wd_cnt   <= '0;
            r_cs_hold  <= 1'b1;
            r_spi_cs   <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b1;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_din      <= 8'hFF;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sig_ack  <= sd_signal;
                        r_cmd      <= sd_cmd;
                        r_shift    <= sd_out;
                        r_edge_cnt <= '0;
                        r_wd_cnt   <= '0;
                        r_timeout  <= 1'b0;
                        r_busy     <= 1'b1;
                        if (sd_cmd == CMD_XFER) r_mosi   <= sd_out[7];
                        if (sd_cmd == CMD_INIT) r_spi_cs <= 1'b1;
                    end else if (r_spi_cs) begin
                        r_wd_cnt <= '0;
                    end else if (r_wd_cnt == WD_LAST) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    end
                end
                INIT: begin
                    if (w_tick) begin
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + 8'd1;
                    end
                    if (w_done) begin
                        r_spi_cs <= r_cs_hold;
                        r_busy   <= 1'b0;
                    end
                end
                XFER: begin
                    if (w_tick) r_edge_cnt <= r_edge_cnt + 8'd1;
                    if (w_rise) begin
                        r_sclk  <= 1'b1;
                        r_shift <= {r_shift[6:0], spi_miso};
                    end
                    if (w_fall) begin
                        r_sclk <= 1'b0;
                        r_mosi <= r_shift[7];
                    end
                    if (w_done) begin
                        r_din  <= r_shift;
                        r_mosi <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                CS: begin
                    r_spi_cs  <= (r_cmd == CMD_CE1);
                    r_cs_hold <= (r_cmd == CMD_CE1);
                    r_busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sd_din     = r_din;
    assign sd_busy    = r_busy;
    assign sd_timeout = r_timeout;
    assign spi_cs     = r_spi_cs;
    assign spi_sclk   = r_sclk;
    assign spi_mosi   = r_mosi;

endmodule
